freq_meter_array: RTL and testbench

FREQ_METER_ARRAY -- requirements
Module: freq_meter_array

---
 rtl/freq_meter_array.sv | 213 +++++++++++++++++++++
 tb/tb_freq_meter_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_array.sv
// Multi-channel frequency meter: gated edge counting against clk_ocxo, then a
// per-channel signed ppm error through one shared restoring divider.
//
// state | meaning
// IDLE  | waiting for en with start (one-shot) or mode=1 (continuous)
// GATE  | counting synchronised rising edges for GATE_CYCLES cycles
// CALC  | dividing each channel's scaled error, channel 0 first
// PUB   | counts and errors published, done high
module freq_meter_array #(
    parameter int     N_CH        = 15,
    parameter int     CNT_W       = 32,
    parameter longint GATE_CYCLES = 100000000,
    parameter longint NOM_COUNT   = GATE_CYCLES,
    parameter int     ERR_W       = 24
) (
    input  logic                    clk_ocxo,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    start,
    input  logic [N_CH-1:0]         f_in,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH*CNT_W-1:0]   count_bus,
    output logic [N_CH*ERR_W-1:0]   err_bus
);

    localparam int NUM_W = CNT_W + 20;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IT_W  = $clog2(NUM_W + 1);

    localparam logic [IT_W-1:0]  DIV_LOAD  = IT_W'(NUM_W);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] NOM       = CNT_W'(NOM_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [NUM_W-1:0] POS_LIM   = NUM_W'((longint'(1) << (ERR_W - 1)) - 1);
    localparam logic [NUM_W-1:0] NEG_LIM   = POS_LIM + NUM_W'(1);

    typedef enum logic [1:0] {IDLE, GATE, CALC, PUB} state_t;

    // Release of rst reaches the rest of the block only after two clk_ocxo edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_ocxo or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [N_CH-1:0] sync1_q, sync2_q, prev_q, edge_w;

    always_ff @(posedge clk_ocxo or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= f_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
    assign edge_w = sync2_q & ~prev_q;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            gate_q, gate_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [IT_W-1:0]             it_q, it_d;
    logic [CNT_W-1:0]            rem_q, rem_d;
    logic [NUM_W-1:0]            quo_q, quo_d;
    logic                        neg_q, neg_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0][ERR_W-1:0]  err_sh_q, err_sh_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_pub_q, cnt_pub_d;
    logic [N_CH-1:0][ERR_W-1:0]  err_pub_q, err_pub_d;

    logic [CNT_W-1:0] sel_cnt;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] mag;
    logic [CNT_W:0]   rem_sh;
    logic             ge;
    logic [NUM_W-1:0] quo_nx;
    logic [ERR_W-1:0] err_res;

    assign sel_cnt = cnt_q[ch_q];
    assign diff    = {1'b0, sel_cnt} - {1'b0, NOM};
    assign mag     = diff[CNT_W] ? CNT_W'(-diff) : diff[CNT_W-1:0];
    assign rem_sh  = {rem_q, quo_q[NUM_W-1]};
    assign ge      = (rem_sh >= {1'b0, NOM});
    assign quo_nx  = {quo_q[NUM_W-2:0], ge};

    // Magnitude was divided, so negating afterwards truncates toward zero.
    always_comb begin
        err_res = quo_nx[ERR_W-1:0];
        if (neg_q) begin
            if (quo_nx > NEG_LIM) err_res = {1'b1, {(ERR_W-1){1'b0}}};
            else                  err_res = -quo_nx[ERR_W-1:0];
        end else if (quo_nx > POS_LIM) begin
            err_res = {1'b0, {(ERR_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        ch_d      = ch_q;
        it_d      = it_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        err_sh_d  = err_sh_q;
        cnt_pub_d = cnt_pub_q;
        err_pub_d = err_pub_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && (mode || start)) begin
                    state_d = GATE;
                    gate_d  = GATE_LAST;
                    cnt_d   = '0;
                end
            end
            GATE: begin
                busy = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    if (edge_w[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + 1'b1;
                end
                if (!en) begin
                    state_d = IDLE;
                end else if (gate_q == '0) begin
                    state_d = CALC;
                    ch_d    = '0;
                    it_d    = DIV_LOAD;
                end else begin
                    gate_d = gate_q - 1'b1;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (!en) begin
                    state_d = IDLE;
                end else if (it_q == DIV_LOAD) begin
                    rem_d = '0;
                    neg_d = diff[CNT_W];
                    quo_d = NUM_W'(mag) * NUM_W'(1000000);
                    it_d  = it_q - 1'b1;
                end else begin
                    rem_d = CNT_W'(ge ? (rem_sh - {1'b0, NOM}) : rem_sh);
                    quo_d = quo_nx;
                    if (it_q == '0) begin
                        err_sh_d[ch_q] = err_res;
                        it_d           = DIV_LOAD;
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            state_d   = PUB;
                            cnt_pub_d = cnt_q;
                            err_pub_d = err_sh_d;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        it_d = it_q - 1'b1;
                    end
                end
            end
            PUB: begin
                done = 1'b1;
                if (mode && en) begin
                    state_d = GATE;
                    gate_d  = GATE_LAST;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ocxo or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            ch_q      <= '0;
            it_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            err_sh_q  <= '0;
            cnt_pub_q <= '0;
            err_pub_q <= '0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            ch_q      <= ch_d;
            it_q      <= it_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            err_sh_q  <= err_sh_d;
            cnt_pub_q <= cnt_pub_d;
            err_pub_q <= err_pub_d;
        end
    end

    assign count_bus = cnt_pub_q;
    assign err_bus   = err_pub_q;

endmodule

// File: tb/tb_freq_meter_array.sv
// Directed and randomised bench for freq_meter_array: periodic channel clocks
// whose periods divide the gate, checked against a plain-arithmetic ppm model.
module tb_freq_meter_array;

    localparam int     N_CH  = 2;
    localparam int     CNT_W = 16;
    localparam longint GATE  = 1000;
    localparam longint NOM   = 250;
    localparam int     ERR_W = 24;

    logic                    clk_ocxo = 1'b0;
    logic                    rst, en, mode, start;
    logic [N_CH-1:0]         f_in = '0;
    logic                    busy, done, busy_s, done_s;
    logic [N_CH*CNT_W-1:0]   count_bus, count_bus_s;
    logic [N_CH*ERR_W-1:0]   err_bus, err_bus_s;

    int checks = 0;
    int errors = 0;

    int per [N_CH];
    int off [N_CH];
    int cyc = 0;
    int divs [15] = '{2, 4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250, 500, 1000};

    freq_meter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE),
                       .NOM_COUNT(NOM), .ERR_W(ERR_W)) dut (
        .clk_ocxo(clk_ocxo), .rst(rst), .en(en), .mode(mode), .start(start),
        .f_in(f_in), .busy(busy), .done(done), .count_bus(count_bus), .err_bus(err_bus));

    freq_meter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE),
                       .NOM_COUNT(1), .ERR_W(ERR_W)) dut_sat (
        .clk_ocxo(clk_ocxo), .rst(rst), .en(en), .mode(mode), .start(start),
        .f_in(f_in), .busy(busy_s), .done(done_s), .count_bus(count_bus_s), .err_bus(err_bus_s));

    always #5 clk_ocxo = ~clk_ocxo;

    always @(negedge clk_ocxo) begin
        cyc = cyc + 1;
        for (int i = 0; i < N_CH; i++)
            f_in[i] = (per[i] == 0) ? 1'b0 : (((cyc + off[i]) % per[i]) < (per[i] / 2));
    end

    function automatic longint cnt_f(input logic [N_CH*CNT_W-1:0] bus, input int ch);
        return longint'(bus[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic longint err_f(input logic [N_CH*ERR_W-1:0] bus, input int ch);
        logic signed [ERR_W-1:0] v;
        v = bus[ch*ERR_W +: ERR_W];
        return longint'(v);
    endfunction

    function automatic longint exp_cnt(input int p);
        return (p == 0) ? 0 : GATE / p;
    endfunction

    function automatic longint model_err(input longint c, input longint nom);
        longint e;
        e = (c - nom) * 1000000 / nom;
        if (e > 8388607)  e = 8388607;
        if (e < -8388608) e = -8388608;
        return e;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int busy_cyc, output bit got, output int n);
        busy_cyc = 0;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk_ocxo);
            n++;
        end
    endtask

    task automatic count_dones(input int cycles, output int nd, output int nb);
        nd = 0;
        nb = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_ocxo);
            if (done) nd++;
            if (busy) nb++;
        end
    endtask

    task automatic check_results(input string tag, input int p0, input int p1);
        check({tag, "_cnt0"}, cnt_f(count_bus, 0), exp_cnt(p0));
        check({tag, "_cnt1"}, cnt_f(count_bus, 1), exp_cnt(p1));
        check({tag, "_err0"}, err_f(err_bus, 0), model_err(exp_cnt(p0), NOM));
        check({tag, "_err1"}, err_f(err_bus, 1), model_err(exp_cnt(p1), NOM));
        check({tag, "_sat_err0"}, err_f(err_bus_s, 0), model_err(exp_cnt(p0), 1));
        check({tag, "_sat_err1"}, err_f(err_bus_s, 1), model_err(exp_cnt(p1), 1));
    endtask

    initial begin
        int  bc, n, nd, nb, p0, p1;
        bit  got;

        rst = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0;
        per[0] = 0; per[1] = 0; off[0] = 0; off[1] = 0;
        repeat (3) @(negedge clk_ocxo);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count_bus", count_bus, 0);
        check("rst_err_bus", err_bus, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk_ocxo);

        // one-shot: periods 4 and 5
        per[0] = 4; per[1] = 5;
        repeat (8) @(negedge clk_ocxo);
        en = 1'b1; mode = 1'b0; start = 1'b1;
        @(negedge clk_ocxo);
        start = 1'b0;
        wait_done(3000, bc, got, n);
        check("oneshot_done", got, 1);
        check("oneshot_busy_cycles", bc, 1074);
        check_results("oneshot", 4, 5);
        check("oneshot_err1_value", err_f(err_bus, 1), -200000);
        @(negedge clk_ocxo);
        check("oneshot_idle_after", busy, 0);
        count_dones(1200, nd, nb);
        check("oneshot_extra_done", nd, 0);
        check("oneshot_hold_cnt0", cnt_f(count_bus, 0), 250);

        // randomised one-shots; first one keeps channel 1 idle
        for (int r = 0; r < 3; r++) begin
            p0 = divs[$urandom_range(0, 14)];
            p1 = (r == 0) ? 0 : divs[$urandom_range(0, 14)];
            per[0] = p0; per[1] = p1;
            off[0] = int'($urandom_range(0, 999)); off[1] = int'($urandom_range(0, 999));
            repeat (8) @(negedge clk_ocxo);
            start = 1'b1;
            @(negedge clk_ocxo);
            start = 1'b0;
            wait_done(3000, bc, got, n);
            check("rand_done", got, 1);
            check_results("rand", p0, p1);
            @(negedge clk_ocxo);
        end

        // continuous: ch0 period 2, ch1 period 10
        per[0] = 2; per[1] = 10;
        repeat (8) @(negedge clk_ocxo);
        mode = 1'b1;
        wait_done(3000, bc, got, n);
        check("cont_first_done", got, 1);
        @(negedge clk_ocxo);
        wait_done(3000, bc, got, n);
        check("cont_second_done", got, 1);
        check("cont_period", n + 1, 1075);
        check_results("cont", 2, 10);
        check("cont_err0_value", err_f(err_bus, 0), 1000000);
        check("cont_sat_err0_value", err_f(err_bus_s, 0), 8388607);

        // abort at gate cycle 500
        repeat (500) @(negedge clk_ocxo);
        check("abort_busy_before", busy, 1);
        en = 1'b0;
        @(negedge clk_ocxo);
        check("abort_idle_next", busy, 0);
        count_dones(1200, nd, nb);
        check("abort_no_done", nd, 0);
        check_results("abort_hold", 2, 10);

        // mode cleared mid-gate: measurement completes, then back to IDLE
        per[1] = 0;
        repeat (8) @(negedge clk_ocxo);
        en = 1'b1;
        repeat (100) @(negedge clk_ocxo);
        mode = 1'b0;
        wait_done(3000, bc, got, n);
        check("modechg_done", got, 1);
        check_results("modechg", 2, 0);
        count_dones(200, nd, nb);
        check("modechg_idle_busy", nb, 0);

        // reset mid-CALC
        start = 1'b1;
        @(negedge clk_ocxo);
        start = 1'b0;
        repeat (1030) @(negedge clk_ocxo);
        check("rstcalc_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("rstcalc_busy", busy, 0);
        check("rstcalc_done", done, 0);
        check("rstcalc_count_bus", count_bus, 0);
        check("rstcalc_err_bus", err_bus, 0);
        @(negedge clk_ocxo);
        rst = 1'b1;
        count_dones(1200, nd, nb);
        check("rstcalc_no_done", nd, 0);
        check("rstcalc_no_busy", nb, 0);

        // startup latency after reset release with continuous enable
        rst = 1'b0;
        mode = 1'b1;
        @(negedge clk_ocxo);
        rst = 1'b1;
        @(negedge clk_ocxo);
        check("release_first_edge_idle", busy, 0);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_ocxo);
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        check("release_gate_starts", got, 1);
        en = 1'b0;
        repeat (3) @(negedge clk_ocxo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
